// File: rtl/ifu_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: next-PC select codes,
// fetch FSM state encodings and the branch-offset helper.
package ifu_fetch_pkg;

  // Next-PC select codes driven by the control decoder (Zero already folded in)
  localparam logic [1:0] NPC_PLUS4  = 2'b00;
  localparam logic [1:0] NPC_BRANCH = 2'b01;
  localparam logic [1:0] NPC_JUMP   = 2'b10;
  localparam logic [1:0] NPC_JREG   = 2'b11;

  // Fetch FSM state encodings
  localparam logic [1:0] ST_RST_ENC   = 2'b00;
  localparam logic [1:0] ST_FETCH_ENC = 2'b01;
  localparam logic [1:0] ST_EXEC_ENC  = 2'b10;

  typedef enum logic [1:0] {
    ST_RST   = ST_RST_ENC,
    ST_FETCH = ST_FETCH_ENC,
    ST_EXEC  = ST_EXEC_ENC
  } fetch_state_e;

  // Branch displacement: sign-extended 16-bit word offset scaled to bytes
  function automatic logic signed [31:0] branch_offset(input logic [15:0] imm);
    logic signed [31:0] ext;
    ext = {{16{imm[15]}}, imm};
    return ext <<< 2;
  endfunction

endpackage

// File: rtl/ifu_fetch_if.sv
// Instruction-memory request/response bundle between the fetch unit and memory.
interface ifu_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/ifu_fetch_npc_calc.sv
// Combinational next-PC selection: sequential, branch, jump or register target.
// Only the low 26 instruction bits matter here (jump index, which also covers
// the 16-bit branch immediate), so only those are brought in.
module npc_calc
  import ifu_fetch_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [25:0] inst,
  input  logic [31:0] rs_data,
  input  logic [1:0]  npc_op,
  output logic [31:0] next_pc
);

  logic        [31:0] pc4;
  logic signed [31:0] br_tgt;
  logic        [31:0] sel;

  assign pc4    = pc + 32'd4;
  assign br_tgt = $signed(pc4) + branch_offset(inst[15:0]);

  // Select the target; the result is word-aligned regardless of source
  always_comb begin
    sel = pc4;
    unique case (npc_op)
      NPC_PLUS4:  sel = pc4;
      NPC_BRANCH: sel = br_tgt;
      NPC_JUMP:   sel = {pc4[31:28], inst, 2'b00};
      NPC_JREG:   sel = rs_data;
      default:    sel = pc4;
    endcase
  end

  assign next_pc = sel & 32'hFFFF_FFFC;

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: holds the PC, fetches one word per instruction over a
// req/ready handshake, presents it to decode and commits the decoder's next PC.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rstn,
  ifu_fetch_if.master      imem,
  output logic [31:0]      inst,
  output logic             inst_valid,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  input  logic [1:0]       npc_op,
  input  logic [31:0]      rs_data,
  input  logic             stall,
  output logic [CNT_W-1:0] instret
);

  fetch_state_e     state_q;
  logic [31:0]      pc_q;
  logic [31:0]      pc_d;
  logic [31:0]      inst_q;
  logic             req_q;
  logic             vld_q;
  logic [CNT_W-1:0] instret_q;
  logic [CNT_W-1:0] instret_d;

  npc_calc u_npc_calc (
    .pc      (pc_q),
    .inst    (inst_q[25:0]),
    .rs_data (rs_data),
    .npc_op  (npc_op),
    .next_pc (pc_d)
  );

  assign instret_d = instret_q + CNT_W'(1);

  // Fetch FSM with registered request/valid; reset abandons any open transaction
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_RST;
      pc_q      <= RESET_PC;
      inst_q    <= 32'd0;
      req_q     <= 1'b0;
      vld_q     <= 1'b0;
      instret_q <= '0;
    end else begin
      unique case (state_q)
        ST_RST: begin
          state_q <= ST_FETCH;
          req_q   <= 1'b1;
        end
        ST_FETCH: begin
          if (imem.imem_ready) begin
            inst_q  <= imem.imem_rdata;
            state_q <= ST_EXEC;
            req_q   <= 1'b0;
            vld_q   <= 1'b1;
          end
        end
        ST_EXEC: begin
          if (!stall) begin
            pc_q      <= pc_d;
            instret_q <= instret_d;
            state_q   <= ST_FETCH;
            req_q     <= 1'b1;
            vld_q     <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_RST;
          req_q   <= 1'b0;
          vld_q   <= 1'b0;
        end
      endcase
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc_q;
  assign inst           = inst_q;
  assign inst_valid     = vld_q;
  assign pc             = pc_q;
  assign pc_plus4       = pc_q + 32'd4;
  assign instret        = instret_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: directed scenarios followed by randomized instruction
// traffic, all compared against a transaction-level reference model.
module tb_ifu_fetch;

  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rstn;
  logic [31:0]      inst;
  logic             inst_valid;
  logic [31:0]      pc;
  logic [31:0]      pc_plus4;
  logic [1:0]       npc_op;
  logic [31:0]      rs_data;
  logic             stall;
  logic [CNT_W-1:0] instret;

  ifu_fetch_if imem ();

  ifu_fetch #(
    .RESET_PC (32'h0000_3000),
    .CNT_W    (CNT_W)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .imem       (imem),
    .inst       (inst),
    .inst_valid (inst_valid),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .npc_op     (npc_op),
    .rs_data    (rs_data),
    .stall      (stall),
    .instret    (instret)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_pc;
  logic [31:0] m_inst;
  logic [31:0] m_ret;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Architectural next-PC rule written as plain arithmetic
  function automatic logic [31:0] ref_npc(input logic [31:0] p, input logic [31:0] w,
                                          input logic [31:0] r, input logic [1:0] op);
    logic [31:0] t;
    int          off;
    off = int'($signed(w[15:0]));
    case (op)
      2'd0:    t = p + 32'd4;
      2'd1:    t = p + 32'd4 + 32'(off * 4);
      2'd2:    t = ((p + 32'd4) & 32'hF000_0000) + ((w & 32'h03FF_FFFF) * 32'd4);
      default: t = r;
    endcase
    return t & ~32'd3;
  endfunction

  task automatic do_reset;
    rstn = 1'b0;
    #1;
    m_pc   = 32'h0000_3000;
    m_inst = 32'd0;
    m_ret  = 32'd0;
    chk("rst_req", {31'd0, imem.imem_req}, 32'd0);
    chk("rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_pc", pc, m_pc);
    chk("rst_inst", inst, m_inst);
    chk("rst_instret", instret, m_ret);
    step;
    chk("rst_hold_req", {31'd0, imem.imem_req}, 32'd0);
    rstn = 1'b1;
    step;
  endtask

  // One full instruction: FETCH with wait states, EXEC with stalls, commit
  task automatic run_instr(input logic [31:0] word, input int waits, input logic [1:0] op,
                           input logic [31:0] rs, input int stalls);
    chk("fetch_req", {31'd0, imem.imem_req}, 32'd1);
    chk("fetch_addr", imem.imem_addr, m_pc);
    chk("fetch_valid", {31'd0, inst_valid}, 32'd0);
    chk("fetch_inst_hold", inst, m_inst);
    for (int i = 0; i < waits; i++) begin
      imem.imem_ready = 1'b0;
      imem.imem_rdata = $urandom;
      npc_op          = 2'($urandom);
      rs_data         = $urandom;
      step;
      chk("wait_req", {31'd0, imem.imem_req}, 32'd1);
      chk("wait_addr", imem.imem_addr, m_pc);
      chk("wait_inst_hold", inst, m_inst);
    end
    imem.imem_ready = 1'b1;
    imem.imem_rdata = word;
    step;
    m_inst = word;
    chk("exec_valid", {31'd0, inst_valid}, 32'd1);
    chk("exec_req", {31'd0, imem.imem_req}, 32'd0);
    chk("exec_inst", inst, m_inst);
    chk("exec_pc", pc, m_pc);
    chk("exec_pc4", pc_plus4, m_pc + 32'd4);
    chk("exec_instret", instret, m_ret);
    imem.imem_ready = 1'($urandom);
    imem.imem_rdata = $urandom;
    npc_op          = op;
    rs_data         = rs;
    stall           = 1'b1;
    for (int i = 0; i < stalls; i++) begin
      step;
      chk("stall_valid", {31'd0, inst_valid}, 32'd1);
      chk("stall_pc", pc, m_pc);
      chk("stall_instret", instret, m_ret);
      chk("stall_inst", inst, m_inst);
    end
    stall = 1'b0;
    step;
    m_pc  = ref_npc(m_pc, word, rs, op);
    m_ret = m_ret + 32'd1;
    imem.imem_ready = 1'b0;
    chk("commit_pc", pc, m_pc);
    chk("commit_instret", instret, m_ret);
    chk("commit_valid", {31'd0, inst_valid}, 32'd0);
    chk("commit_inst_keep", inst, m_inst);
  endtask

  initial begin
    rstn            = 1'b0;
    imem.imem_ready = 1'b0;
    imem.imem_rdata = 32'd0;
    npc_op          = 2'b00;
    rs_data         = 32'd0;
    stall           = 1'b0;
    m_pc            = 32'h0000_3000;
    m_inst          = 32'd0;
    m_ret           = 32'd0;
    step;
    do_reset;

    // First fetch with zero-wait memory
    chk("first_addr", imem.imem_addr, 32'h0000_3000);
    run_instr($urandom, 0, 2'b00, 32'd0, 0);
    chk("first_pc", pc, 32'h0000_3004);
    chk("first_instret", instret, 32'd1);

    // Three wait states, then redirect to 0x3010 through jr
    run_instr($urandom, 3, 2'b11, 32'h0000_3010, 0);
    chk("jr_3010", pc, 32'h0000_3010);

    // Backward and forward branches
    run_instr({6'h04, 10'h000, 16'hFFFE}, 0, 2'b01, $urandom, 0);
    chk("branch_back", pc, 32'h0000_300C);
    run_instr({6'h04, 10'h000, 16'h0003}, 0, 2'b01, $urandom, 0);
    chk("branch_fwd", pc, 32'h0000_301C);

    // Jump then jr with a misaligned register value
    run_instr($urandom, 0, 2'b11, 32'h0000_3000, 0);
    run_instr({6'h02, 26'h000_0C10}, 1, 2'b10, $urandom, 0);
    chk("jump", pc, 32'h0000_3040);
    run_instr($urandom, 0, 2'b11, 32'h0000_3007, 0);
    chk("jr_align", pc, 32'h0000_3004);

    // Two stall cycles before commit
    run_instr($urandom, 0, 2'b00, 32'd0, 2);
    chk("stall_commit_pc", pc, 32'h0000_3008);

    // Reset during a pending fetch at 0x3008
    imem.imem_ready = 1'b0;
    step;
    chk("midfetch_req", {31'd0, imem.imem_req}, 32'd1);
    do_reset;
    chk("after_reset_addr", imem.imem_addr, 32'h0000_3000);

    // Randomized traffic
    for (int n = 0; n < 150; n++) begin
      run_instr($urandom, int'($urandom_range(0, 2)), 2'($urandom), $urandom,
                int'($urandom_range(0, 2)));
    end

    // Address wrap-around
    run_instr($urandom, 0, 2'b11, 32'hFFFF_FFFC, 0);
    chk("wrap_pre", pc, 32'hFFFF_FFFC);
    run_instr($urandom, 0, 2'b00, 32'd0, 0);
    chk("wrap_pc", pc, 32'h0000_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
